// File: rtl/verificador_clusters_pkg.sv
// Shared types and default widths for the candidate buffer / cluster verifier pair.
package verificador_clusters_pkg;

  localparam int NUM_CLUSTERS  = 8;
  localparam int TAM_ENDERECO  = 2;
  localparam int TAM_HASH_DOIS = 8;

  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO  = 2'd0;
  localparam estado_t COMPARA = 2'd1;
  localparam estado_t ESPERA  = 2'd2;

  // Index of the lowest set bit; callers zero-extend bitmaps of up to 32 bits.
  function automatic int unsigned menor_bit(input logic [31:0] v);
    menor_bit = 0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (v[i-1]) menor_bit = i - 1;
    end
  endfunction

endpackage

// File: rtl/tabela_hash_clusters.sv
// Banked {valido, hash} table: one bank per cluster, synchronous write,
// registered read-first port, valid bits cleared on reset.
module tabela_hash_clusters #(
  parameter int NUM_CLUSTERS  = 8,
  parameter int TAM_ENDERECO  = 2,
  parameter int TAM_HASH_DOIS = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            we,
  input  logic [$clog2(NUM_CLUSTERS)-1:0] wr_cluster,
  input  logic [TAM_ENDERECO-1:0]         wr_endereco,
  input  logic [TAM_HASH_DOIS-1:0]        wr_hash,
  input  logic                            wr_valido,
  input  logic                            rd_en,
  input  logic [$clog2(NUM_CLUSTERS)-1:0] rd_cluster,
  input  logic [TAM_ENDERECO-1:0]         rd_endereco,
  output logic [TAM_HASH_DOIS-1:0]        rd_hash,
  output logic                            rd_valido
);

  localparam int IW    = $clog2(NUM_CLUSTERS);
  localparam int AW    = IW + TAM_ENDERECO;
  localparam int DEPTH = 2 ** AW;

  logic [TAM_HASH_DOIS-1:0] hashes [DEPTH];
  logic [DEPTH-1:0]         validos;
  logic [AW-1:0]            wa;
  logic [AW-1:0]            ra;

  assign wa = {wr_cluster, wr_endereco};
  assign ra = {rd_cluster, rd_endereco};

  // Hash storage carries no reset; its contents only matter behind a valid bit.
  always_ff @(posedge clk) begin
    if (we) hashes[wa] <= wr_hash;
  end

  // Valid bits: cleared by reset, written alongside the hash.
  always_ff @(posedge clk) begin
    if (reset)   validos     <= '0;
    else if (we) validos[wa] <= wr_valido;
  end

  // Registered read; non-blocking update makes a same-cycle write return old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valido <= 1'b0;
      rd_hash   <= '0;
    end else if (rd_en) begin
      rd_valido <= validos[ra];
      rd_hash   <= hashes[ra];
    end
  end

endmodule

// File: rtl/verificador_clusters.sv
// Probes the set clusters of the buffer head entry against the per-cluster
// hash tables, writes back the shrinking bitmap and pulses zero/suspeito to pop.
module verificador_clusters #(
  parameter int NUM_CLUSTERS  = 8,
  parameter int TAM_ENDERECO  = 2,
  parameter int TAM_HASH_DOIS = 8,
  parameter int TAM_CONTADOR  = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            saida_valida,
  input  logic [NUM_CLUSTERS-1:0]         bitmap_atual,
  input  logic [TAM_ENDERECO-1:0]         endereco_atual,
  input  logic [TAM_HASH_DOIS-1:0]        hash_atual,
  output logic [NUM_CLUSTERS-1:0]         bitmap_atualizado,
  output logic                            zero,
  output logic                            suspeito,
  input  logic                            tab_we,
  input  logic [$clog2(NUM_CLUSTERS)-1:0] tab_cluster,
  input  logic [TAM_ENDERECO-1:0]         tab_endereco,
  input  logic [TAM_HASH_DOIS-1:0]        tab_hash,
  input  logic                            tab_valido,
  output logic                            alerta_valido,
  output logic [$clog2(NUM_CLUSTERS)-1:0] alerta_cluster,
  output logic [TAM_ENDERECO-1:0]         alerta_endereco,
  output logic [TAM_HASH_DOIS-1:0]        alerta_hash,
  output logic [TAM_CONTADOR-1:0]         contador_suspeitos
);
  import verificador_clusters_pkg::*;

  localparam int IW = $clog2(NUM_CLUSTERS);

  estado_t                  estado;
  logic [IW-1:0]            idx_q;
  logic [IW-1:0]            idx_novo;
  logic [TAM_HASH_DOIS-1:0] hash_q;
  logic [TAM_HASH_DOIS-1:0] rd_hash;
  logic                     rd_valido;
  logic                     rd_en;
  logic                     casou;
  logic [NUM_CLUSTERS-1:0]  mascarado;

  tabela_hash_clusters #(
    .NUM_CLUSTERS (NUM_CLUSTERS),
    .TAM_ENDERECO (TAM_ENDERECO),
    .TAM_HASH_DOIS(TAM_HASH_DOIS)
  ) u_tabela (
    .clk        (clk),
    .reset      (reset),
    .we         (tab_we),
    .wr_cluster (tab_cluster),
    .wr_endereco(tab_endereco),
    .wr_hash    (tab_hash),
    .wr_valido  (tab_valido),
    .rd_en      (rd_en),
    .rd_cluster (idx_novo),
    .rd_endereco(endereco_atual),
    .rd_hash    (rd_hash),
    .rd_valido  (rd_valido)
  );

  // Lowest pending cluster, compare result and the bitmap written back every cycle.
  always_comb begin
    idx_novo          = IW'(menor_bit(32'(bitmap_atual)));
    rd_en             = (estado == OCIOSO) && saida_valida && (|bitmap_atual);
    casou             = rd_valido && (rd_hash == hash_q);
    mascarado         = bitmap_atual & ~(NUM_CLUSTERS'(1) << idx_q);
    bitmap_atualizado = bitmap_atual;
    if (estado == COMPARA && !casou) bitmap_atualizado = mascarado;
  end

  // Probe FSM with registered one-cycle pop/alert pulses and saturating match count.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado             <= OCIOSO;
      idx_q              <= '0;
      hash_q             <= '0;
      zero               <= 1'b0;
      suspeito           <= 1'b0;
      alerta_valido      <= 1'b0;
      alerta_cluster     <= '0;
      alerta_endereco    <= '0;
      alerta_hash        <= '0;
      contador_suspeitos <= '0;
    end else begin
      zero          <= 1'b0;
      suspeito      <= 1'b0;
      alerta_valido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (saida_valida) begin
            if (bitmap_atual == '0) begin
              zero   <= 1'b1;
              estado <= ESPERA;
            end else begin
              idx_q  <= idx_novo;
              hash_q <= hash_atual;
              estado <= COMPARA;
            end
          end
        end
        COMPARA: begin
          if (!saida_valida) begin
            estado <= OCIOSO;
          end else if (casou) begin
            suspeito        <= 1'b1;
            alerta_valido   <= 1'b1;
            alerta_cluster  <= idx_q;
            alerta_endereco <= endereco_atual;
            alerta_hash     <= hash_q;
            if (contador_suspeitos != '1)
              contador_suspeitos <= contador_suspeitos + 1'b1;
            estado <= ESPERA;
          end else if (mascarado == '0) begin
            zero   <= 1'b1;
            estado <= ESPERA;
          end else begin
            estado <= OCIOSO;
          end
        end
        ESPERA:  estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: doc/verificador_clusters.md
Name: verificador_clusters

Overview:
- Downstream consumer of the candidate circular buffer.
- Each head entry holds a cluster bitmap, a bucket address and a second-level hash. The block probes the set clusters of that entry one at a time against per-cluster hash tables.
- It writes the shrinking bitmap back, and pulses zero (all clusters rejected) or suspeito (hash match) so the buffer pops the head.
- Matches are reported on an alert port and counted.

Parameters:
- NUM_CLUSTERS, 8, number of clusters; bitmap width and number of hash-table banks.
- TAM_ENDERECO, 2, bucket address width; each bank holds 2**TAM_ENDERECO entries.
- TAM_HASH_DOIS, 8, second-level hash width.
- TAM_CONTADOR, 16, width of the saturating suspect counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- saida_valida  input  1  buffer head entry valid
- bitmap_atual  input  NUM_CLUSTERS  head bitmap
- endereco_atual  input  TAM_ENDERECO  head bucket address
- hash_atual  input  TAM_HASH_DOIS  head hash
- bitmap_atualizado  output  NUM_CLUSTERS  bitmap written back to head
- zero  output  1  pop pulse: no cluster left
- suspeito  output  1  pop pulse: match found
- tab_we  input  1  hash-table write enable
- tab_cluster  input  $clog2(NUM_CLUSTERS)  bank to write
- tab_endereco  input  TAM_ENDERECO  entry to write
- tab_hash  input  TAM_HASH_DOIS  stored hash
- tab_valido  input  1  stored valid bit
- alerta_valido  output  1  one-cycle match report
- alerta_cluster  output  $clog2(NUM_CLUSTERS)  matching cluster
- alerta_endereco  output  TAM_ENDERECO  matching address
- alerta_hash  output  TAM_HASH_DOIS  matching hash
- contador_suspeitos  output  TAM_CONTADOR  total matches, saturating

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - FSM goes to OCIOSO.
  - All table valid bits clear; hash contents are don't-care.
  - zero, suspeito and alerta_valido are 0; alerta_* data is 0; contador_suspeitos is 0.
  - Reset mid-probe abandons the probe with no pulse.
- bitmap_atualizado is combinational. It equals bitmap_atual in every cycle, except a COMPARA mismatch cycle, where it equals bitmap_atual & ~(1<<idx). The buffer writes it back every non-pop cycle, so it must never be stale.
- Table:
  - NUM_CLUSTERS x 2**TAM_ENDERECO entries of {valido, hash}.
  - Synchronous write on tab_we.
  - Registered read: one cycle of latency.
  - Same-cycle write and read to the same location returns the OLD data.
- FSM:
  - OCIOSO:
    - If saida_valida and bitmap_atual==0: zero=1 for 1 cycle, go to ESPERA.
    - If saida_valida and bitmap_atual!=0: idx = lowest set bit; latch idx and hash_atual; issue a read at (idx, endereco_atual); go to COMPARA.
    - Otherwise stay in OCIOSO.
  - COMPARA:
    - Match = read valido && read hash == latched hash.
    - On match: suspeito=1, alerta_valido=1 with {idx, endereco_atual, latched hash}, contador_suspeitos increments (saturates at all-ones). Go to ESPERA.
    - On mismatch: clear bit idx in bitmap_atualizado. If the cleared bitmap is 0, zero=1 and go to ESPERA; otherwise go to OCIOSO.
  - ESPERA: go to OCIOSO unconditionally. This one bubble lets the buffer's ini/ocupacao settle after a pop.
- zero and suspeito are mutually exclusive and each is exactly one cycle wide.
- Latency: each probe takes 2 cycles; each pop costs 1 extra bubble cycle.
- If saida_valida drops while in COMPARA (not expected from the buffer): finish the compare, emit no pulse, return to OCIOSO.
- Table writes are accepted in every state, including during probes.

Decomposition:
- Shared package: the FSM state enum (OCIOSO, COMPARA, ESPERA) and the default widths NUM_CLUSTERS, TAM_ENDERECO, TAM_HASH_DOIS. These are shared with the circular buffer.
- One sub-module, tabela_hash_clusters: banked table with a registered read port, a write port and a valid-bit clear on reset.
- The lowest-set-bit priority encoder is a package function.

Test Plan:
- Tables empty; head bitmap 8'b0000_0101, address 1 -> mismatch clears bit 0 (bitmap_atualizado 8'b0000_0100), then bit 2; zero pulses once, cycle 4 after entry.
- Write bank 2, address 3, hash 8'hA5, valid; head {8'b0000_0100, 3, 8'hA5} -> suspeito and alerta_valido pulse together with alerta_cluster=2, alerta_endereco=3; counter becomes 1.
- Head bitmap 0 with saida_valida=1 -> zero pulses the next cycle, with no table read.
- Write bank 2, address 3, hash 8'hA5 in the same cycle the read of (2, 3) is issued -> old data is used: mismatch, no alert.
- Preload contador_suspeitos to 16'hFFFF via repeated matches (or force) -> it stays at 16'hFFFF after one more match.
- Assert reset during COMPARA -> no pulse, FSM returns to OCIOSO, all valid bits are 0, so a previously matching entry now mismatches.
